fp_add_scheduler: RTL and testbench

Sequencing and arbitration controller for the shared floating-point adder (32-bit words, bit 0 sign, bits [1:6] exponent, bits [7:31] mantissa, 4-bit status). Two requesters submit operand pairs through valid/ready handshakes. The scheduler grants one request at a time by round-robin and launches the adder with a one-cycle start pulse. It then waits for the adder's done, bounded by a timeout, and returns the result and status to the granted requester as a one-cycle response pulse.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/fp_add_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fp_add_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder scheduler.
package fp_pkg;

    // Word layout: bit 0 sign, bits 1..6 exponent, bits 7..31 mantissa.
    typedef logic [0:31] fp_word_t;
    typedef logic [0:3]  fp_status_t;

    localparam int unsigned FP_SIGN     = 0;
    localparam int unsigned FP_EXP_MSB  = 1;
    localparam int unsigned FP_EXP_LSB  = 6;
    localparam int unsigned FP_MANT_MSB = 7;
    localparam int unsigned FP_MANT_LSB = 31;

    // Adder status flag positions.
    localparam int unsigned ST_EXACT   = 0;
    localparam int unsigned ST_OVF     = 1;
    localparam int unsigned ST_UNF     = 2;
    localparam int unsigned ST_INEXACT = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: a lone request wins, a tie goes to the
// requester that was not granted last. One-hot grant, all-zero when idle.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the winner from the request pair and the last-grant pointer.
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Scheduler for the shared floating-point adder: accepts one of two
// requesters by round-robin, launches the adder, waits (bounded) for done
// and returns the result to the granted requester as a one-cycle pulse.
module fp_add_scheduler
    import fp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clock_100kHz,
    input  logic       reset,
    input  logic       req_valid_0,
    input  logic       req_valid_1,
    output logic       req_ready_0,
    output logic       req_ready_1,
    input  fp_word_t   req_a_0,
    input  fp_word_t   req_a_1,
    input  fp_word_t   req_b_0,
    input  fp_word_t   req_b_1,
    output logic       fpu_start,
    output fp_word_t   fpu_op_A,
    output fp_word_t   fpu_op_B,
    input  logic       fpu_done,
    input  fp_word_t   fpu_data,
    input  fp_status_t fpu_status,
    output logic       rsp_valid_0,
    output logic       rsp_valid_1,
    output fp_word_t   rsp_data,
    output fp_status_t rsp_status,
    output logic       rsp_timeout,
    output logic       err_spurious_done
);

    // Last timer value spent in WAIT before the operation is abandoned.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    sched_state_t state, state_next;
    logic [7:0]   timer;
    logic         last_grant;
    logic         grant_idx;
    logic [1:0]   grant;
    logic         xfer;
    logic         wait_done;
    logic         wait_timeout;
    fp_word_t     cap_data;
    fp_status_t   cap_status;
    logic         cap_timeout;
    logic         err_q;

    rr_arbiter2 u_arb (
        .req        ({req_valid_1, req_valid_0}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Next-state logic and handshake/pulse outputs decoded from the state.
    always_comb begin
        state_next   = state;
        req_ready_0  = 1'b0;
        req_ready_1  = 1'b0;
        fpu_start    = 1'b0;
        rsp_valid_0  = 1'b0;
        rsp_valid_1  = 1'b0;
        rsp_timeout  = 1'b0;
        xfer         = 1'b0;
        wait_done    = 1'b0;
        wait_timeout = 1'b0;
        case (state)
            IDLE: begin
                req_ready_0 = grant[0];
                req_ready_1 = grant[1];
                if ((req_valid_0 && grant[0]) || (req_valid_1 && grant[1])) begin
                    xfer       = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                fpu_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // A done arriving on the last permitted cycle still wins.
                if (fpu_done) begin
                    wait_done  = 1'b1;
                    state_next = RESPOND;
                end else if (timer == TIMER_LAST) begin
                    wait_timeout = 1'b1;
                    state_next   = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid_0 = ~grant_idx;
                rsp_valid_1 = grant_idx;
                rsp_timeout = cap_timeout;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset returns to IDLE at once, abandoning any operation.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Latch the granted operands and remember which requester owns them.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            fpu_op_A  <= '0;
            fpu_op_B  <= '0;
            grant_idx <= 1'b0;
        end else if (xfer) begin
            fpu_op_A  <= grant[1] ? req_a_1 : req_a_0;
            fpu_op_B  <= grant[1] ? req_b_1 : req_b_0;
            grant_idx <= grant[1];
        end
    end

    // WAIT timer: cleared while issuing, counts idle WAIT cycles, saturates at the limit.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT && !fpu_done && timer != TIMER_LAST) begin
            timer <= timer + 8'd1;
        end
    end

    // Capture the adder result, or a zeroed timeout response.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            cap_data    <= '0;
            cap_status  <= '0;
            cap_timeout <= 1'b0;
        end else if (wait_done) begin
            cap_data    <= fpu_data;
            cap_status  <= fpu_status;
            cap_timeout <= 1'b0;
        end else if (wait_timeout) begin
            cap_data    <= '0;
            cap_status  <= '0;
            cap_timeout <= 1'b1;
        end
    end

    // Round-robin pointer advances only once the response has been delivered.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset)                 last_grant <= 1'b1;
        else if (state == RESPOND) last_grant <= grant_idx;
    end

    // Sticky flag for an adder done that arrives when nothing is waiting for it.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset)                         err_q <= 1'b0;
        else if (fpu_done && state != WAIT) err_q <= 1'b1;
    end

    assign rsp_data          = cap_data;
    assign rsp_status        = cap_status;
    assign err_spurious_done = err_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler: a cycle-indexed transaction
// model checked at every falling edge, plus directed literal checks.
module tb_fp_add_scheduler;
    import fp_pkg::*;

    localparam int TO = 8;

    logic       clock_100kHz = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic       req_ready_0, req_ready_1;
    fp_word_t   req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
    logic       fpu_start;
    fp_word_t   fpu_op_A, fpu_op_B;
    logic       fpu_done = 1'b0;
    fp_word_t   fpu_data = '0;
    fp_status_t fpu_status = '0;
    logic       rsp_valid_0, rsp_valid_1;
    fp_word_t   rsp_data;
    fp_status_t rsp_status;
    logic       rsp_timeout;
    logic       err_spurious_done;

    always #5 clock_100kHz = ~clock_100kHz;

    fp_add_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clock_100kHz      (clock_100kHz),
        .reset             (reset),
        .req_valid_0       (req_valid_0),
        .req_valid_1       (req_valid_1),
        .req_ready_0       (req_ready_0),
        .req_ready_1       (req_ready_1),
        .req_a_0           (req_a_0),
        .req_a_1           (req_a_1),
        .req_b_0           (req_b_0),
        .req_b_1           (req_b_1),
        .fpu_start         (fpu_start),
        .fpu_op_A          (fpu_op_A),
        .fpu_op_B          (fpu_op_B),
        .fpu_done          (fpu_done),
        .fpu_data          (fpu_data),
        .fpu_status        (fpu_status),
        .rsp_valid_0       (rsp_valid_0),
        .rsp_valid_1       (rsp_valid_1),
        .rsp_data          (rsp_data),
        .rsp_status        (rsp_status),
        .rsp_timeout       (rsp_timeout),
        .err_spurious_done (err_spurious_done)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clock_100kHz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Adder stand-in: answers ad_lat cycles after the start pulse (0 = never).
    int         ad_lat   = 1;
    int         ad_cnt   = 0;
    bit         ad_spur  = 0;
    bit         ad_fixed = 0;
    fp_word_t   ad_fix_d = '0;
    fp_status_t ad_fix_s = '0;

    initial forever begin
        @(posedge clock_100kHz);
        #2;
        fpu_done = 1'b0;
        if (ad_cnt > 0) begin
            ad_cnt--;
            if (ad_cnt == 0) begin
                fpu_done   = 1'b1;
                fpu_data   = ad_fixed ? ad_fix_d : fp_word_t'($urandom);
                fpu_status = ad_fixed ? ad_fix_s : fp_status_t'($urandom);
            end
        end
        if (ad_spur) begin
            fpu_done = 1'b1;
            ad_spur  = 0;
        end
        if (fpu_start) ad_cnt = ad_lat;
    end

    // Transaction model: an accepted request in cycle x starts the adder in
    // x+1, waits from x+2, answers one cycle after done or after x+1+TO.
    bit         m_busy = 0;
    int         m_x    = 0;
    int         m_g    = 0;
    int         m_last = 1;
    bit         m_err  = 0;
    int         m_rsp  = -1;
    fp_word_t   m_a, m_b, m_cd;
    fp_status_t m_cs;
    bit         m_cto;
    int         pick;
    bit         e_start, e_rsp, in_wait;

    always @(negedge clock_100kHz) begin
        if (reset) begin
            check("rst_start",   fpu_start,         0);
            check("rst_rsp0",    rsp_valid_0,       0);
            check("rst_rsp1",    rsp_valid_1,       0);
            check("rst_rdy0",    req_ready_0,       0);
            check("rst_rdy1",    req_ready_1,       0);
            check("rst_opA",     fpu_op_A,          0);
            check("rst_opB",     fpu_op_B,          0);
            check("rst_rdata",   rsp_data,          0);
            check("rst_rstatus", rsp_status,        0);
            check("rst_rto",     rsp_timeout,       0);
            check("rst_err",     err_spurious_done, 0);
            m_busy = 0;
            m_last = 1;
            m_err  = 0;
            m_rsp  = -1;
        end else begin
            pick = -1;
            if (!m_busy) begin
                if (req_valid_0 && req_valid_1) pick = (m_last == 1) ? 0 : 1;
                else if (req_valid_0)           pick = 0;
                else if (req_valid_1)           pick = 1;
            end
            e_start = m_busy && (cyc == m_x + 1);
            e_rsp   = m_busy && (cyc == m_rsp);
            in_wait = m_busy && (cyc >= m_x + 2) && (m_rsp < 0);

            check("ready0", req_ready_0, (pick == 0) ? 1 : 0);
            check("ready1", req_ready_1, (pick == 1) ? 1 : 0);
            check("start",  fpu_start,   e_start ? 1 : 0);
            check("rsp0",   rsp_valid_0, (e_rsp && m_g == 0) ? 1 : 0);
            check("rsp1",   rsp_valid_1, (e_rsp && m_g == 1) ? 1 : 0);
            check("rto",    rsp_timeout, (e_rsp && m_cto) ? 1 : 0);
            check("err",    err_spurious_done, m_err);
            if (m_busy) begin
                check("opA", fpu_op_A, m_a);
                check("opB", fpu_op_B, m_b);
            end
            if (e_rsp) begin
                check("rdata",   rsp_data,   m_cd);
                check("rstatus", rsp_status, m_cs);
            end

            if (fpu_done && !in_wait) m_err = 1;
            if (in_wait) begin
                if (fpu_done) begin
                    m_rsp = cyc + 1; m_cd = fpu_data; m_cs = fpu_status; m_cto = 0;
                end else if (cyc == m_x + 1 + TO) begin
                    m_rsp = cyc + 1; m_cd = '0; m_cs = '0; m_cto = 1;
                end
            end
            if (e_rsp) begin
                m_busy = 0;
                m_last = m_g;
                m_rsp  = -1;
            end else if (pick >= 0) begin
                m_busy = 1;
                m_x    = cyc;
                m_g    = pick;
                m_a    = (pick == 0) ? req_a_0 : req_a_1;
                m_b    = (pick == 0) ? req_b_0 : req_b_1;
            end
        end
    end

    task automatic wait_rsp(input int limit, output bit seen);
        seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clock_100kHz);
            #3;
            if (rsp_valid_0 || rsp_valid_1) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int       x;
    bit       seen;
    fp_word_t ga, gb;

    initial begin
        repeat (3) @(posedge clock_100kHz);
        #1 reset = 1'b0;

        // Simultaneous requests alternate 0,1,0,1 starting from requester 0.
        for (int r = 0; r < 4; r++) begin
            @(posedge clock_100kHz); #1;
            req_valid_0 = 1; req_valid_1 = 1;
            req_a_0 = $urandom; req_b_0 = $urandom;
            req_a_1 = $urandom; req_b_1 = $urandom;
            ad_lat  = $urandom_range(1, 4);
            #2;
            check("tie_grant0", req_ready_0, (r % 2 == 0) ? 1 : 0);
            check("tie_grant1", req_ready_1, (r % 2 == 1) ? 1 : 0);
            ga = (r % 2 == 0) ? req_a_0 : req_a_1;
            gb = (r % 2 == 0) ? req_b_0 : req_b_1;
            @(posedge clock_100kHz); #1;
            req_valid_0 = 0; req_valid_1 = 0;
            #2;
            check("tie_opA", fpu_op_A, ga);
            check("tie_opB", fpu_op_B, gb);
            repeat (10) @(posedge clock_100kHz);
        end

        // Single request: adder answers 3 cycles after start, response at x+5.
        @(posedge clock_100kHz); #1;
        ad_fixed = 1; ad_fix_d = 32'h40E00000; ad_fix_s = 4'b1000; ad_lat = 3;
        req_valid_0 = 1; req_a_0 = 32'h40800000; req_b_0 = 32'h40400000;
        #2;
        check("single_ready", req_ready_0, 1);
        x = cyc;
        @(posedge clock_100kHz); #1;
        req_valid_0 = 0;
        #2;
        check("single_start", fpu_start, 1);
        wait_rsp(20, seen);
        check("single_seen",   seen, 1);
        check("single_lat",    cyc - x, 5);
        check("single_rsp0",   rsp_valid_0, 1);
        check("single_rsp1",   rsp_valid_1, 0);
        check("single_data",   rsp_data, 32'h40E00000);
        check("single_status", rsp_status, 4'b1000);
        ad_fixed = 0;
        repeat (3) @(posedge clock_100kHz);

        // Adder never answers: timeout response at x+10, then requester 1 accepted.
        @(posedge clock_100kHz); #1;
        ad_lat = 0;
        req_valid_0 = 1; req_a_0 = $urandom; req_b_0 = $urandom;
        #2;
        check("to_ready", req_ready_0, 1);
        x = cyc;
        @(posedge clock_100kHz); #1;
        req_valid_0 = 0;
        req_valid_1 = 1; req_a_1 = $urandom; req_b_1 = $urandom;
        wait_rsp(30, seen);
        check("to_seen",    seen, 1);
        check("to_lat",     cyc - x, 10);
        check("to_rsp0",    rsp_valid_0, 1);
        check("to_flag",    rsp_timeout, 1);
        check("to_data",    rsp_data, 0);
        check("to_status",  rsp_status, 0);
        ad_lat = 2;
        @(posedge clock_100kHz); #3;
        check("to_next_rdy1", req_ready_1, 1);
        @(posedge clock_100kHz); #1;
        req_valid_1 = 0;
        repeat (10) @(posedge clock_100kHz);

        // Done while idle raises the sticky error flag.
        #3;
        check("spur_before", err_spurious_done, 0);
        @(posedge clock_100kHz); #1;
        ad_spur = 1;
        @(posedge clock_100kHz); #3;
        check("spur_after", err_spurious_done, 1);

        // Randomized traffic checked entirely by the model.
        for (int i = 0; i < 400; i++) begin
            @(posedge clock_100kHz); #1;
            req_valid_0 = ($urandom % 3) != 0;
            req_valid_1 = ($urandom % 3) != 0;
            req_a_0 = $urandom; req_b_0 = $urandom;
            req_a_1 = $urandom; req_b_1 = $urandom;
            ad_lat  = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 10));
            ad_spur = ($urandom % 25) == 0;
        end
        @(posedge clock_100kHz); #1;
        req_valid_0 = 0; req_valid_1 = 0; ad_spur = 0; ad_lat = 2;
        repeat (30) @(posedge clock_100kHz);
        #3;
        check("spur_sticky", err_spurious_done, 1);

        // Reset during WAIT: outputs drop at once, late done flagged spurious.
        @(posedge clock_100kHz); #1;
        ad_lat = 6;
        req_valid_0 = 1; req_a_0 = $urandom; req_b_0 = $urandom;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock_100kHz); #1;
            req_valid_0 = 0;
            if (fpu_start) begin
                seen = 1;
                break;
            end
        end
        check("rw_started", seen, 1);
        repeat (2) @(posedge clock_100kHz);
        #3 reset = 1'b1;
        #1;
        check("rw_start", fpu_start, 0);
        check("rw_rsp0",  rsp_valid_0, 0);
        check("rw_rsp1",  rsp_valid_1, 0);
        check("rw_opA",   fpu_op_A, 0);
        check("rw_opB",   fpu_op_B, 0);
        check("rw_err",   err_spurious_done, 0);
        @(posedge clock_100kHz); #1;
        reset = 1'b0;
        repeat (8) @(posedge clock_100kHz);
        #3;
        check("rw_late_done", err_spurious_done, 1);

        // First tie after reset goes to requester 0.
        @(posedge clock_100kHz); #1;
        ad_lat = 2;
        req_valid_0 = 1; req_valid_1 = 1;
        #2;
        check("post_rst_tie0", req_ready_0, 1);
        check("post_rst_tie1", req_ready_1, 0);
        @(posedge clock_100kHz); #1;
        req_valid_0 = 0; req_valid_1 = 0;
        repeat (10) @(posedge clock_100kHz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
